axi4_lite_biu_fifo: RTL

//  AXI4-Lite slave to BIU bridge, next generation of the single-entry BIU: per-channel FIFOs
//  (AW, W, AR requests; B, R responses) allow multiple outstanding transfers at one per cycle.

---
 rtl/axi4_lite_biu_fifo_pkg.sv | 20 ++
 rtl/axi4_lite_biu_fifo_sync_fifo.sv | 70 +++++++
 rtl/axi4_lite_biu_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_biu_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axi_biu_pkg
//   Shared types for the AXI4-Lite to BIU bridge.
//   axi_resp_t : 2-bit AXI response code (OKAY / EXOKAY / SLVERR / DECERR).
//   biu_resp() : maps a BIU error flag onto the response the bridge reports.
// -----------------------------------------------------------------------------
package axi_biu_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    function automatic axi_resp_t biu_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_biu_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// axi_biu_sync_fifo
//   Single-clock FIFO with registered full/empty flags and a combinational
//   head output (zero while empty). Pointers carry an extra wrap bit.
//   A push while full or a pop while empty is ignored; a full FIFO refuses a
//   push even when it is popped in the same cycle.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              remove head entry
//   full, empty      registered occupancy flags
//   head             oldest entry, '0 when empty
// -----------------------------------------------------------------------------
module axi_biu_sync_fifo
    import axi_biu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr, rptr, wptr_nxt, rptr_nxt;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_nxt = do_push ? wptr + PTR_ONE : wptr;
        rptr_nxt = do_pop  ? rptr + PTR_ONE : rptr;
    end

    // Flags are computed from the next pointers so they stay registered
    // without lagging the pointer update by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            empty <= (wptr_nxt == rptr_nxt);
            full  <= (wptr_nxt[PW] != rptr_nxt[PW]) &&
                     (wptr_nxt[PW-1:0] == rptr_nxt[PW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[PW-1:0]] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rptr[PW-1:0]];

endmodule

// File: rtl/axi4_lite_biu_fifo.sv
// -----------------------------------------------------------------------------
// axi4_lite_biu_fifo
//   AXI4-Lite slave to BIU bridge with per-channel FIFOs (AW, W, AR requests;
//   B, R responses) so several transfers can be outstanding, one per cycle
//   per path. Write and read paths are independent.
// Ports
//   S_AXI_ACLK / S_AXI_ARESETn        clock, asynchronous active-low reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*     AXI4-Lite write channels
//   S_AXI_AR*, S_AXI_R*               AXI4-Lite read channels
//   biu_waddr/wdata/wben/wenable      BIU write request (FIFO heads)
//   biu_waccept/werror                BIU write completion
//   biu_raddr/renable                 BIU read request
//   biu_rdata/raccept/rerror          BIU read completion
// Configuration
//   AXI_BIU_TIMEOUT_EN : when defined, a request not accepted within
//   TIMEOUT_CYCLES cycles completes on its own with SLVERR (read data 0).
// -----------------------------------------------------------------------------
module axi4_lite_biu_fifo
    import axi_biu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REQ_DEPTH      = 4,
    parameter int unsigned RESP_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETn,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [ADDR_WIDTH-1:0]   biu_waddr,
    output logic [DATA_WIDTH-1:0]   biu_wdata,
    output logic [DATA_WIDTH/8-1:0] biu_wben,
    output logic                    biu_wenable,
    input  logic                    biu_waccept,
    input  logic                    biu_werror,
    output logic [ADDR_WIDTH-1:0]   biu_raddr,
    output logic                    biu_renable,
    input  logic [DATA_WIDTH-1:0]   biu_rdata,
    input  logic                    biu_raccept,
    input  logic                    biu_rerror
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    logic                        aw_full, aw_empty;
    logic [ADDR_WIDTH-1:0]       aw_head;
    logic                        w_full, w_empty;
    logic [DATA_WIDTH+SW-1:0]    w_head;
    logic                        b_full, b_empty;
    logic [1:0]                  b_head;
    logic                        ar_full, ar_empty;
    logic [ADDR_WIDTH-1:0]       ar_head;
    logic                        r_full, r_empty;
    logic [DATA_WIDTH+1:0]       r_head;

    logic                        w_to, r_to;
    logic                        w_done, r_done;
    axi_resp_t                   w_resp, r_resp;
    logic [DATA_WIDTH-1:0]       r_data_in;
    logic                        unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- request side ----------------
    axi_biu_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(REQ_DEPTH)) u_aw_fifo (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETn),
        .push(S_AXI_AWVALID), .push_data(S_AXI_AWADDR), .pop(w_done),
        .full(aw_full), .empty(aw_empty), .head(aw_head)
    );

    axi_biu_sync_fifo #(.WIDTH(DATA_WIDTH + SW), .DEPTH(REQ_DEPTH)) u_w_fifo (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETn),
        .push(S_AXI_WVALID), .push_data({S_AXI_WDATA, S_AXI_WSTRB}), .pop(w_done),
        .full(w_full), .empty(w_empty), .head(w_head)
    );

    axi_biu_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(REQ_DEPTH)) u_ar_fifo (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETn),
        .push(S_AXI_ARVALID), .push_data(S_AXI_ARADDR), .pop(r_done),
        .full(ar_full), .empty(ar_empty), .head(ar_head)
    );

    assign S_AXI_AWREADY = ~aw_full;
    assign S_AXI_WREADY  = ~w_full;
    assign S_AXI_ARREADY = ~ar_full;

    // ---------------- BIU issue ----------------
    assign biu_wenable = ~aw_empty & ~w_empty & ~b_full;
    assign biu_waddr   = biu_wenable ? aw_head : '0;
    assign biu_wdata   = biu_wenable ? w_head[DATA_WIDTH+SW-1:SW] : '0;
    assign biu_wben    = biu_wenable ? w_head[SW-1:0] : '0;

    assign biu_renable = ~ar_empty & ~r_full;
    assign biu_raddr   = biu_renable ? ar_head : '0;

`ifdef AXI_BIU_TIMEOUT_EN
    localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   T_ONE   = 1;

    logic [TW-1:0] w_cnt, r_cnt;

    assign w_to = biu_wenable & ~biu_waccept & (w_cnt == T_LAST);
    assign r_to = biu_renable & ~biu_raccept & (r_cnt == T_LAST);

    // Counters restart on accept, on idle, and after a self-completion so the
    // next queued request gets its own full window.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
        if (!S_AXI_ARESETn) begin
            w_cnt <= '0;
            r_cnt <= '0;
        end else begin
            w_cnt <= (biu_wenable & ~biu_waccept & ~w_to) ? w_cnt + T_ONE : '0;
            r_cnt <= (biu_renable & ~biu_raccept & ~r_to) ? r_cnt + T_ONE : '0;
        end
    end
`else
    assign w_to = 1'b0;
    assign r_to = 1'b0;
`endif

    // A self-completed request reports SLVERR regardless of the error inputs.
    assign w_done    = biu_wenable & (biu_waccept | w_to);
    assign r_done    = biu_renable & (biu_raccept | r_to);
    assign w_resp    = biu_waccept ? biu_resp(biu_werror) : RESP_SLVERR;
    assign r_resp    = biu_raccept ? biu_resp(biu_rerror) : RESP_SLVERR;
    assign r_data_in = biu_raccept ? biu_rdata : '0;

    // ---------------- response side ----------------
    axi_biu_sync_fifo #(.WIDTH(2), .DEPTH(RESP_DEPTH)) u_b_fifo (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETn),
        .push(w_done), .push_data(w_resp), .pop(S_AXI_BREADY),
        .full(b_full), .empty(b_empty), .head(b_head)
    );

    axi_biu_sync_fifo #(.WIDTH(DATA_WIDTH + 2), .DEPTH(RESP_DEPTH)) u_r_fifo (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETn),
        .push(r_done), .push_data({r_data_in, r_resp}), .pop(S_AXI_RREADY),
        .full(r_full), .empty(r_empty), .head(r_head)
    );

    assign S_AXI_BVALID = ~b_empty;
    assign S_AXI_BRESP  = b_head;
    assign S_AXI_RVALID = ~r_empty;
    assign S_AXI_RDATA  = r_head[DATA_WIDTH+1:2];
    assign S_AXI_RRESP  = r_head[1:0];

endmodule
